// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and line levels.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitIdle
   } rx_state_e;

   localparam int unsigned DATA_BITS = 8;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out
);

   logic meta_q;
   logic sync_q;

   // Resets to 1 so an idle-high line never looks like a start edge out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
      end
   end

   assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receiver: mid-bit sampling of 8N1 frames, valid/ready byte output with
// framing-error and overrun pulses.
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned HALF  = CLKS_PER_BIT / 2;

   localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       IDX_LAST    = 3'(DATA_BITS - 1);

   logic rx_s;

   rx_state_e            state_q;
   logic [CNT_W-1:0]     bit_cnt_q;
   logic [2:0]           bit_idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 commit_q;
   logic                 frame_err_q;

   logic [7:0]           rx_data_q;
   logic                 rx_valid_q;
   logic                 overrun_q;

   uart_rx_sync u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (rx),
      .sync_out (rx_s)
   );

   // Frame FSM: start validation, bit-centre sampling, stop check.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         commit_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         commit_q    <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (rx_s == START_BIT) begin
                  state_q   <= StStart;
                  bit_cnt_q <= '0;
               end
            end
            StStart: begin
               if (bit_cnt_q == CNT_HALF_M1) begin
                  bit_cnt_q <= '0;
                  bit_idx_q <= '0;
                  // A start bit that is gone by its centre is treated as a glitch.
                  state_q   <= (rx_s == START_BIT) ? StData : StIdle;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            StData: begin
               if (bit_cnt_q == CNT_LAST) begin
                  shift_q[bit_idx_q] <= rx_s;
                  bit_cnt_q          <= '0;
                  if (bit_idx_q == IDX_LAST) begin
                     state_q <= StStop;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            StStop: begin
               if (bit_cnt_q == CNT_LAST) begin
                  bit_cnt_q <= '0;
                  if (rx_s == STOP_BIT) begin
                     commit_q <= 1'b1;
                     state_q  <= StIdle;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= StWaitIdle;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            StWaitIdle: begin
               // Hold off until the line recovers so a stuck-low line is not re-read.
               if (rx_s == IDLE_LEVEL) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Output register: load on commit, clear on handshake, flag overrun on a full slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (commit_q) begin
            if (!rx_valid_q || rx_ready) begin
               rx_data_q  <= shift_q;
               rx_valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 16 clocks per bit.
module tb_uart_rx_deframer;

   localparam int unsigned CPB = 16;
   // Pin fall to rx_valid visible: 2 sync + 1 idle detect + HALF + 9*CPB + 1.
   localparam int LATENCY = 156;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // Monitor state, updated on the falling edge.
   int         rise_cnt = 0;
   int         hi_cnt = 0;
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   int         rise_cyc = 0;
   int         ov_cyc = 0;
   logic       valid_prev = 1'b0;
   logic [7:0] rise_log [64];

   always #5 clk = ~clk;

   uart_rx_deframer #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      valid_prev <= rx_valid;
      if (rx_valid === 1'b1 && valid_prev !== 1'b1) begin
         rise_log[rise_cnt % 64] <= rx_data;
         rise_cnt <= rise_cnt + 1;
         rise_cyc <= cyc;
      end
      if (rx_valid === 1'b1) hi_cnt <= hi_cnt + 1;
      if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
      if (overrun === 1'b1) begin
         ov_cnt <= ov_cnt + 1;
         ov_cyc <= cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int c0);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      c0 = cyc;
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         repeat (CPB) tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rx = 1'b1;
      repeat (3) tick();
      tests++;
      if (rx_data !== 8'h00) begin
         fails++;
         $display("FAIL reset_data: got %h expected 00", rx_data);
      end
      tests++;
      if (rx_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_valid: got %b expected 0", rx_valid);
      end
      tests++;
      if (frame_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_frame_err: got %b expected 0", frame_err);
      end
      tests++;
      if (overrun !== 1'b0) begin
         fails++;
         $display("FAIL reset_overrun: got %b expected 0", overrun);
      end
      reset = 1'b0;
      idle(4);
   endtask

   task automatic test_basic();
      int c0, r0, h0, f0, o0;
      rx_ready = 1'b1;
      r0 = rise_cnt; h0 = hi_cnt; f0 = fe_cnt; o0 = ov_cnt;
      send_frame(8'hA5, 1'b1, c0);
      idle(4);
      tests++;
      if (rise_cnt - r0 !== 1) begin
         fails++;
         $display("FAIL basic_rises: got %0d expected 1", rise_cnt - r0);
      end
      tests++;
      if (rise_log[r0 % 64] !== 8'hA5) begin
         fails++;
         $display("FAIL basic_data: got %h expected a5", rise_log[r0 % 64]);
      end
      tests++;
      if (rise_cyc - c0 !== LATENCY) begin
         fails++;
         $display("FAIL basic_latency: got %0d expected %0d", rise_cyc - c0, LATENCY);
      end
      tests++;
      if (hi_cnt - h0 !== 1) begin
         fails++;
         $display("FAIL basic_valid_width: got %0d expected 1", hi_cnt - h0);
      end
      tests++;
      if (fe_cnt - f0 !== 0) begin
         fails++;
         $display("FAIL basic_frame_err: got %0d expected 0", fe_cnt - f0);
      end
      tests++;
      if (ov_cnt - o0 !== 0) begin
         fails++;
         $display("FAIL basic_overrun: got %0d expected 0", ov_cnt - o0);
      end
   endtask

   task automatic test_glitch();
      int c0, r0, f0;
      r0 = rise_cnt; f0 = fe_cnt;
      rx = 1'b0;
      repeat (4) tick();
      idle(30);
      tests++;
      if (rise_cnt - r0 !== 0) begin
         fails++;
         $display("FAIL glitch_valid: got %0d rises expected 0", rise_cnt - r0);
      end
      tests++;
      if (fe_cnt - f0 !== 0) begin
         fails++;
         $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt - f0);
      end
      send_frame(8'h3C, 1'b1, c0);
      idle(4);
      tests++;
      if (rise_cnt - r0 !== 1 || rise_log[r0 % 64] !== 8'h3C) begin
         fails++;
         $display("FAIL glitch_next_frame: got %0d rises data %h expected 1 rise data 3c",
                  rise_cnt - r0, rise_log[r0 % 64]);
      end
   endtask

   task automatic test_framing();
      int c0, r0, f0;
      r0 = rise_cnt; f0 = fe_cnt;
      send_frame(8'h3C, 1'b0, c0);
      rx = 1'b0;
      repeat (40) tick();
      idle(20);
      tests++;
      if (fe_cnt - f0 !== 1) begin
         fails++;
         $display("FAIL framing_pulses: got %0d expected 1", fe_cnt - f0);
      end
      tests++;
      if (rise_cnt - r0 !== 0) begin
         fails++;
         $display("FAIL framing_valid: got %0d rises expected 0", rise_cnt - r0);
      end
      send_frame(8'h81, 1'b1, c0);
      idle(4);
      tests++;
      if (rise_cnt - r0 !== 1 || rise_log[r0 % 64] !== 8'h81) begin
         fails++;
         $display("FAIL framing_recover: got %0d rises data %h expected 1 rise data 81",
                  rise_cnt - r0, rise_log[r0 % 64]);
      end
      tests++;
      if (fe_cnt - f0 !== 1) begin
         fails++;
         $display("FAIL framing_recover_err: got %0d expected 1", fe_cnt - f0);
      end
   endtask

   task automatic test_overrun();
      int ca, cb, r0, o0, f0;
      rx_ready = 1'b0;
      r0 = rise_cnt; o0 = ov_cnt; f0 = fe_cnt;
      send_frame(8'h11, 1'b1, ca);
      send_frame(8'h22, 1'b1, cb);
      idle(4);
      tests++;
      if (rx_valid !== 1'b1) begin
         fails++;
         $display("FAIL overrun_valid_held: got %b expected 1", rx_valid);
      end
      tests++;
      if (rx_data !== 8'h11) begin
         fails++;
         $display("FAIL overrun_data_kept: got %h expected 11", rx_data);
      end
      tests++;
      if (ov_cnt - o0 !== 1) begin
         fails++;
         $display("FAIL overrun_pulses: got %0d expected 1", ov_cnt - o0);
      end
      tests++;
      if (ov_cyc - cb !== LATENCY) begin
         fails++;
         $display("FAIL overrun_timing: got %0d expected %0d", ov_cyc - cb, LATENCY);
      end
      tests++;
      if (rise_cnt - r0 !== 1 || fe_cnt - f0 !== 0) begin
         fails++;
         $display("FAIL overrun_flags: got %0d rises %0d frame errs expected 1 and 0",
                  rise_cnt - r0, fe_cnt - f0);
      end
      rx_ready = 1'b1;
      tick();
      tick();
      tests++;
      if (rx_valid !== 1'b0) begin
         fails++;
         $display("FAIL overrun_release: got %b expected 0", rx_valid);
      end
   endtask

   task automatic test_back_to_back();
      int ca, cb, r0, h0;
      rx_ready = 1'b1;
      r0 = rise_cnt; h0 = hi_cnt;
      send_frame(8'h00, 1'b1, ca);
      send_frame(8'hFF, 1'b1, cb);
      idle(4);
      tests++;
      if (rise_cnt - r0 !== 2) begin
         fails++;
         $display("FAIL b2b_rises: got %0d expected 2", rise_cnt - r0);
      end
      tests++;
      if (rise_log[r0 % 64] !== 8'h00) begin
         fails++;
         $display("FAIL b2b_first: got %h expected 00", rise_log[r0 % 64]);
      end
      tests++;
      if (rise_log[(r0 + 1) % 64] !== 8'hFF) begin
         fails++;
         $display("FAIL b2b_second: got %h expected ff", rise_log[(r0 + 1) % 64]);
      end
      tests++;
      if (hi_cnt - h0 !== 2) begin
         fails++;
         $display("FAIL b2b_valid_cycles: got %0d expected 2", hi_cnt - h0);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [9:0] bits;
      int c0, r0, f0, o0;
      r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
      bits = {1'b1, 8'h5A, 1'b0};
      // Start bit and data bits 0..3, then half of data bit 4.
      for (int i = 0; i < 5; i++) begin
         rx = bits[i];
         repeat (CPB) tick();
      end
      rx = bits[5];
      repeat (CPB / 2) tick();
      reset = 1'b1;
      tick();
      tests++;
      if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0)
      begin
         fails++;
         $display("FAIL midreset_outputs: got data %h valid %b ferr %b ovr %b expected all 0",
                  rx_data, rx_valid, frame_err, overrun);
      end
      reset = 1'b0;
      idle(40);
      tests++;
      if (rise_cnt - r0 !== 0) begin
         fails++;
         $display("FAIL midreset_valid: got %0d rises expected 0", rise_cnt - r0);
      end
      tests++;
      if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin
         fails++;
         $display("FAIL midreset_flags: got %0d frame errs %0d overruns expected 0",
                  fe_cnt - f0, ov_cnt - o0);
      end
      send_frame(8'hC3, 1'b1, c0);
      idle(4);
      tests++;
      if (rise_cnt - r0 !== 1 || rise_log[r0 % 64] !== 8'hC3) begin
         fails++;
         $display("FAIL midreset_next_frame: got %0d rises data %h expected 1 rise data c3",
                  rise_cnt - r0, rise_log[r0 % 64]);
      end
      tests++;
      if (rise_cyc - c0 !== LATENCY) begin
         fails++;
         $display("FAIL midreset_latency: got %0d expected %0d", rise_cyc - c0, LATENCY);
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_basic();
      test_glitch();
      test_framing();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
